// File: rtl/scv_timing_gen.sv
// CPU phase strobes (CP1/CP2 edges) and frame VBL/INT2 timing for the Super Cassette Vision.
// Define SCV_TIMING_FAST_EN to shrink the frame to 64+16 ticks for faster simulation.
module scv_timing_gen #(
  parameter int unsigned ACTIVE_TICKS = 15109,
  parameter int unsigned VBL_TICKS    = 1558
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  output logic        CP1_POSEDGE,
  output logic        CP1_NEGEDGE,
  output logic        CP2_POSEDGE,
  output logic        CP2_NEGEDGE,
  output logic        VBL,
  output logic        FRAME_START,
  output logic [14:0] POS
);

`ifdef SCV_TIMING_FAST_EN
  localparam int unsigned ACT_T = 64;
  localparam int unsigned BLK_T = 16;
`else
  localparam int unsigned ACT_T = ACTIVE_TICKS;
  localparam int unsigned BLK_T = VBL_TICKS;
`endif

  localparam logic [14:0] POS_ACT  = 15'(ACT_T);
  localparam logic [14:0] POS_LAST = 15'(ACT_T + BLK_T - 1);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  div_q, div_d;
  logic [14:0] pos_q, pos_d;
  logic [3:0]  strobe_q, strobe_d;
  logic        frame_q, frame_d;
  logic        tick_wrap;

  // Counters: phase and tick divider step on every enabled clock.
  always_comb begin
    phase_d   = phase_q;
    div_d     = div_q;
    pos_d     = pos_q;
    tick_wrap = 1'b0;
    if (CE) begin
      phase_d = phase_q + 2'd1;
      div_d   = div_q + 3'd1;
      if (div_q == 3'd7) begin
        tick_wrap = 1'b1;
        pos_d     = (pos_q == POS_LAST) ? 15'd0 : pos_q + 15'd1;
      end
    end
  end

  // Next-state: transitions are keyed on the value POS is about to take.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (tick_wrap && (pos_d == POS_ACT)) state_d = ST_BLANK;
      ST_BLANK:  if (tick_wrap && (pos_d == 15'd0))   state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  // Output decode: one strobe per enabled clock, frame pulse on BLANK->ACTIVE.
  always_comb begin
    strobe_d = 4'b0000;
    frame_d  = 1'b0;
    if (CE) begin
      strobe_d[phase_q] = 1'b1;
      frame_d = (state_q == ST_BLANK) && (state_d == ST_ACTIVE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= ST_ACTIVE;
      phase_q  <= 2'd0;
      div_q    <= 3'd0;
      pos_q    <= 15'd0;
      strobe_q <= 4'b0000;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      pos_q    <= pos_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
    end
  end

  assign CP1_POSEDGE = strobe_q[0];
  assign CP1_NEGEDGE = strobe_q[1];
  assign CP2_POSEDGE = strobe_q[2];
  assign CP2_NEGEDGE = strobe_q[3];
  assign VBL         = (state_q == ST_BLANK);
  assign FRAME_START = frame_q;
  assign POS         = pos_q;

endmodule

// File: doc/scv_timing_gen.md
# scv_timing_gen

Clock-phase and vertical-blank generator for the Super Cassette Vision core. From the single 8 MHz system clock it produces the four CPU phase strobes consumed by `upd7800` (CP1/CP2 rising and falling edges, 2 MHz CPU cycle) and the frame-rate VBL level driven into the CPU's INT2. It sits directly upstream of the CPU and replaces the ad-hoc phase and VBL generation used in simulation benches.

## Interface
Parameters:
- `ACTIVE_TICKS`, default 15109: ticks per frame with VBL low; must be ≥1.
- `VBL_TICKS`, default 1558: ticks per frame with VBL high; must be ≥1.
- Constraint: ACTIVE_TICKS+VBL_TICKS ≤ 32767. One tick is 8 enabled clocks.

Ports:
- `CLK` in 1: system clock, 8 MHz. The block uses this one clock only.
- `RES` in 1: reset, synchronous and active-high.
- `CE` in 1: global clock enable, used for pause. When low, the block holds all state.
- `CP1_POSEDGE` out 1: one-clock strobe for the CP1 rising edge.
- `CP1_NEGEDGE` out 1: one-clock strobe for the CP1 falling edge.
- `CP2_POSEDGE` out 1: one-clock strobe for the CP2 rising edge.
- `CP2_NEGEDGE` out 1: one-clock strobe for the CP2 falling edge.
- `VBL` out 1: vertical-blank level, connected to the CPU INT2 input.
- `FRAME_START` out 1: one-clock pulse marking the first tick of each frame.
- `POS` out 15: tick index within the current frame, range 0..ACTIVE_TICKS+VBL_TICKS−1.

## Operation
- All outputs are registered.
- **Reset.** While RES=1, at each CLK edge:
  - phase counter (2 bits), tick divider (3 bits) and POS all clear to 0;
  - all strobes, VBL and FRAME_START are 0;
  - state is ACTIVE.
- **Phase counter.** Advances once per enabled clock, sequence 0→1→2→3→0.
  - Exactly one strobe is asserted per enabled clock, in the order CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE, then repeating.
- **Tick divider.** Advances once per enabled clock. On wrap from 7 to 0 it increments POS.
  - POS wraps from ACTIVE_TICKS+VBL_TICKS−1 to 0.
  - POS arithmetic is unsigned 15-bit. No overflow is possible under the parameter constraint.
- **State machine** with two states, ACTIVE (VBL=0) and BLANK (VBL=1):
  - ACTIVE→BLANK when POS becomes ACTIVE_TICKS.
  - BLANK→ACTIVE when POS wraps to 0. FRAME_START pulses on that same clock.
  - No FRAME_START pulse is issued on reset exit.
- **CE low.** All counters and VBL hold their values, and all strobes and FRAME_START are forced to 0 on that edge.
  - When CE returns high, the sequence resumes exactly where it stopped: no phase is skipped or repeated.
- **Reset mid-frame.** Takes effect on the next edge regardless of state or CE. VBL drops to 0 immediately.
- RES has priority over CE.

## Timing
- Let edge n be the nth CLK rising edge with RES=0 and CE=1 after reset, with n starting at 1. Outputs are valid after edge n:
  - CP1_POSEDGE=1 when n mod 4 = 1.
  - CP1_NEGEDGE=1 when n mod 4 = 2.
  - CP2_POSEDGE=1 when n mod 4 = 3.
  - CP2_NEGEDGE=1 when n mod 4 = 0.
- Let F = 8×(ACTIVE_TICKS+VBL_TICKS), the frame length in enabled clocks.
  - POS = floor(n/8) mod (F/8).
  - VBL rises after edge 8×ACTIVE_TICKS + kF.
  - VBL falls after edge (k+1)F, for k ≥ 0.
  - FRAME_START is high for exactly the clock after edge (k+1)F.
- With default parameters:
  - F = 133336 clocks, i.e. 16.667 ms (60.00 Hz) at 8 MHz.
  - VBL is high for 12464 clocks per frame and low for 120872.
- Latency from RES falling to the first CP1_POSEDGE is one enabled clock.

## Configuration
- Macro `SCV_TIMING_FAST_EN`.
- **Defined:** for simulation speed, parameters are overridden internally with ACTIVE_TICKS=64 and VBL_TICKS=16, giving F=640 clocks. Phase behaviour is unchanged.
- **Undefined:** the parameter values are used as given.

## Test plan
- **Reset release.** Hold RES=1 for 5 clocks, then release with CE=1.
  - Required: strobe sequence CP1P, CP1N, CP2P, CP2N repeating.
  - Required: exactly one strobe high per clock, over 1000 clocks.
- **Default frame.** Run 2 frames.
  - Required: VBL rises after edge 120872 and falls after edge 133336.
  - Required: FRAME_START pulses once after edge 133336 and once after edge 266672.
  - Required: POS=16666 immediately before the wrap.
- **CE gating.** Deassert CE for 13 clocks right after a CP1_NEGEDGE strobe.
  - Required: no strobes while CE=0.
  - Required: next strobe is CP2_POSEDGE.
  - Required: VBL edges delayed by exactly 13 clocks.
- **Mid-frame reset.** Pulse RES=1 for 1 clock at edge 125000, while VBL=1.
  - Required: VBL=0 and POS=0 on the next clock.
  - Required: no FRAME_START pulse.
  - Required: VBL rises again 120872 enabled clocks later.
- **Fast mode.** With `SCV_TIMING_FAST_EN` defined:
  - Required: VBL rises after edge 512 and falls after edge 640.
  - Required: POS range is 0..79.
- **Minimum parameters.** ACTIVE_TICKS=1, VBL_TICKS=1.
  - Required: VBL toggles every 8 clocks.
  - Required: FRAME_START every 16 clocks.
